// File: rtl/pif_xi_bridge.sv
// I2C-slave-to-XI register bridge: address/data bytes from the I2C layer become
// XI register writes, and read requests fetch one byte from XO per tx_req.
module pif_xi_bridge #(
  parameter int DATA_W = 6,
  parameter int A_W    = 6,
  parameter int SUBA_W = 4,
  parameter int RD_LAT = 6
) (
  input  logic              xclk,
  input  logic              sys_rst,
  input  logic              i2c_start,
  input  logic              i2c_stop,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  input  logic              tx_req,
  output logic [7:0]        tx_byte,
  output logic              tx_valid,
  output logic              busy,
  output logic              xi_pwr,
  output logic [A_W-1:0]    xi_prwa,
  output logic [DATA_W-1:0] xi_pd,
  output logic [SUBA_W-1:0] xi_prdsuba,
  output logic              xi_prdfinished,
  input  logic [7:0]        xo
);

  localparam int CNT_W = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;
  // Loading RD_LAT-1 puts tx_valid RD_LAT+1 cycles after the tx_req cycle.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADDR   = 2'd1,
    DATA   = 2'd2,
    RFETCH = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;

  logic bus_evt;
  logic addr_load;
  logic wr_fire;
  logic fetch_go;
  logic fetch_done;

  // START/STOP outrank every byte-level event in the same cycle.
  assign bus_evt    = i2c_start | i2c_stop;
  assign fetch_go   = ((state == ADDR) || (state == DATA)) && tx_req && !bus_evt;
  assign addr_load  = (state == ADDR) && rx_valid && !tx_req && !bus_evt;
  assign wr_fire    = (state == DATA) && rx_valid && !tx_req && !bus_evt;
  assign fetch_done = (state == RFETCH) && (cnt == '0) && !bus_evt;

  // State register.
  // NOTE: every clocked process uses non-blocking assignments so all registers
  // update together at the edge and read each other's pre-edge values.
  always_ff @(posedge xclk or negedge sys_rst) begin
    if (!sys_rst) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic.
  // NOTE: state_nxt gets a default before any branch, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    if (i2c_start) begin
      state_nxt = ADDR;
    end else if (i2c_stop) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:   state_nxt = IDLE;
        ADDR:   if (tx_req) state_nxt = RFETCH;
                else if (rx_valid) state_nxt = DATA;
        DATA:   if (tx_req) state_nxt = RFETCH;
        RFETCH: if (cnt == '0) state_nxt = DATA;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output logic.
  always_comb begin
    busy = (state == RFETCH);
  end

  // Fetch latency counter; only meaningful while in RFETCH.
  always_ff @(posedge xclk or negedge sys_rst) begin
    if (!sys_rst) begin
      cnt <= '0;
    end else if (fetch_go) begin
      cnt <= CNT_LOAD;
    end else if ((state == RFETCH) && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // XI write side: address latched in ADDR, one strobe per data byte in DATA.
  always_ff @(posedge xclk or negedge sys_rst) begin
    if (!sys_rst) begin
      xi_prwa <= '0;
      xi_pd   <= '0;
      xi_pwr  <= 1'b0;
    end else begin
      xi_pwr <= wr_fire;
      if (addr_load) xi_prwa <= rx_byte[A_W-1:0];
      if (wr_fire)   xi_pd   <= rx_byte[DATA_W-1:0];
    end
  end

  // Read side: capture XO at the end of the fetch, then retire the byte and
  // advance the sub-address one cycle later so it stays stable during RFETCH.
  always_ff @(posedge xclk or negedge sys_rst) begin
    if (!sys_rst) begin
      tx_byte        <= '0;
      tx_valid       <= 1'b0;
      xi_prdfinished <= 1'b0;
      xi_prdsuba     <= '0;
    end else begin
      tx_valid       <= fetch_done;
      xi_prdfinished <= tx_valid;
      if (fetch_done) tx_byte <= xo;
      if (i2c_start)     xi_prdsuba <= '0;
      else if (tx_valid) xi_prdsuba <= xi_prdsuba + SUBA_W'(1);
    end
  end

  a_no_pwr_with_tx: assert property (@(posedge xclk) disable iff (!sys_rst)
    !(xi_pwr && tx_valid));

endmodule

// File: doc/pif_xi_bridge.md
PIF_XI_BRIDGE -- requirements
Module: pif_xi_bridge

Interface
REQ-001 Parameters SHALL be (name, default, meaning): DATA_W, 6, XI write-data width; A_W, 6, XI register-address width; SUBA_W, 4, read sub-address width; RD_LAT, 6, cycles from sub-address presentation to XO sample (≥5).
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset; ports are listed as name, direction, width, meaning.
REQ-003 xclk  in  1  sole clock; all logic on rising edge.
REQ-004 sys_rst  in  1  asynchronous active-low reset.
REQ-005 i2c_start  in  1  one-cycle pulse: I2C START or repeated START seen.
REQ-006 i2c_stop  in  1  one-cycle pulse: I2C STOP seen.
REQ-007 rx_valid  in  1  one-cycle pulse: rx_byte holds a received data byte.
REQ-008 rx_byte  in  8  received data byte, device-address byte already stripped.
REQ-009 tx_req  in  1  one-cycle pulse: master requests the next read byte.
REQ-010 tx_byte  out  8  read byte returned to the I2C layer.
REQ-011 tx_valid  out  1  one-cycle pulse: tx_byte is valid.
REQ-012 busy  out  1  high while a read fetch is in flight.
REQ-013 xi_pwr  out  1  single-cycle register-write strobe.
REQ-014 xi_prwa  out  A_W  register address for both writes and reads.
REQ-015 xi_pd  out  DATA_W  write data.
REQ-016 xi_prdsuba  out  SUBA_W  read sub-address.
REQ-017 xi_prdfinished  out  1  one-cycle pulse: a read byte has been consumed.
REQ-018 xo  in  8  read data returned by the register block.

Function
REQ-019 The transaction FSM SHALL have states IDLE, ADDR, DATA, and RFETCH.
REQ-020 i2c_start from any state SHALL move to ADDR, clear xi_prdsuba to 0, and abort any fetch without asserting tx_valid.
REQ-021 i2c_stop from any state SHALL move to IDLE, abort any fetch, and leave xi_prwa unchanged.
REQ-022 If i2c_start and i2c_stop coincide, i2c_start SHALL win.
REQ-023 In ADDR, rx_valid SHALL load xi_prwa <= rx_byte[A_W-1:0] (upper bits ignored) and move to DATA, with no write strobe.
REQ-024 In DATA, each rx_valid SHALL, on the next cycle, drive xi_pd <= rx_byte[DATA_W-1:0] and pulse xi_pwr for exactly one cycle with the current xi_prwa.
REQ-025 Write auto-increment SHALL NOT occur; consecutive data bytes rewrite the same address.
REQ-026 rx_valid in IDLE or RFETCH SHALL be ignored.
REQ-027 tx_req in ADDR or DATA SHALL enter RFETCH, assert busy, and load an RD_LAT down-counter; xi_prwa and xi_prdsuba SHALL be held stable throughout RFETCH.
REQ-028 On the counter reaching 0, the block SHALL capture tx_byte <= xo, pulse tx_valid for one cycle, deassert busy, and return to DATA.
REQ-029 Total read latency SHALL be RD_LAT+1 cycles from tx_req to tx_valid.
REQ-030 The cycle after tx_valid, the block SHALL pulse xi_prdfinished for one cycle and increment xi_prdsuba modulo 2^SUBA_W (15 wraps to 0).
REQ-031 tx_req during RFETCH or in IDLE SHALL be ignored, with no tx_valid.
REQ-032 xi_pwr and tx_valid SHALL never be high in the same cycle.

Reset
REQ-033 While sys_rst is low, the FSM SHALL be in IDLE and every output SHALL be 0: tx_byte, tx_valid, busy, xi_pwr, xi_prwa, xi_pd, xi_prdsuba, xi_prdfinished.
REQ-034 Reset asserted mid-fetch SHALL abort the fetch with no tx_valid; after release, the first action SHALL require i2c_start.
REQ-035 Reset release SHALL be synchronous in effect: no output changes on the first edge after release unless driven by an input.

Verification
REQ-036 Write: start, rx 0x02, rx 0x15 -> exactly one xi_pwr pulse with xi_prwa=0x02, xi_pd=0x15.
REQ-037 Read: start, rx 0x00, tx_req with xo tied 0x55 -> tx_valid exactly 7 cycles after tx_req, tx_byte=0x55, xi_prdfinished the next cycle, xi_prdsuba=1.
REQ-038 Wrap: 16 consecutive reads -> xi_prdsuba runs 0..15 then 0; no tx_req dropped when requests are spaced ≥RD_LAT+3 cycles apart.
REQ-039 Abort: tx_req, then i2c_start 3 cycles later -> no tx_valid, busy low, state ADDR, xi_prdsuba=0.
REQ-040 Reset mid-fetch: sys_rst low 2 cycles during RFETCH -> all outputs 0; subsequent rx_valid ignored until i2c_start.
REQ-041 Protocol checks: start+stop coincident -> ADDR; rx_valid in IDLE -> no xi_pwr; tx_req in RFETCH -> single tx_valid.
